// File: rtl/frame_parser_pkg.sv
// Shared definitions for the frame parser and its sibling frame builder:
// FSM state encoding and default frame parameters.
package frame_parser_pkg;

  localparam int         DATA_WIDTH_DEF = 8;
  localparam logic [7:0] SOF_BYTE_DEF   = 8'hA5;
  localparam int         MAX_LEN_DEF    = 64;
  localparam int         CNT_WIDTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LEN  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CHK  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_chksum.sv
// Modulo-2^W running checksum with clear/add and a zero test that includes
// the byte currently on din (used to judge the CHK byte without storing it).
module frame_chksum #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         add,
  input  logic [W-1:0] din,
  output logic         zero_with_din
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;
  logic [W-1:0] sum_plus;

  assign sum_plus      = sum_q + din;
  assign zero_with_din = (sum_plus == '0);

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = add ? din : '0;
    end else if (add) begin
      sum_d = sum_plus;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

endmodule

// File: rtl/frame_parser.sv
// Delimits SOF/LEN/payload/CHK frames from the FIFO read side, forwards the
// payload through a one-deep output register and reports per-frame status.
//
// state | meaning
// IDLE  | hunting for SOF, other bytes dropped
// LEN   | expecting LEN byte, seeds checksum
// PAY   | forwarding payload bytes, rem_q counts down
// CHK   | expecting checksum byte, emits status
module frame_parser
  import frame_parser_pkg::*;
#(
  parameter int                    DATA_WIDTH = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] SOF_BYTE   = DATA_WIDTH'(SOF_BYTE_DEF),
  parameter int                    MAX_LEN    = MAX_LEN_DEF,
  parameter int                    CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  rdclk,
  input  logic                  rst,
  output logic                  readValid,
  input  logic                  readReady,
  input  logic [DATA_WIDTH-1:0] readData,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [DATA_WIDTH-1:0] outData,
  output logic                  outLast,
  output logic                  frameDone,
  output logic                  frameErr,
  output logic [CNT_WIDTH-1:0]  okCount,
  output logic [CNT_WIDTH-1:0]  errCount
);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_V = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ONE_V     = DATA_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  ok_cnt_q, ok_cnt_d;
  logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;

  logic rd_fire;
  logic out_take;
  logic ck_clear;
  logic ck_add;
  logic ck_zero;

  frame_chksum #(
    .W (DATA_WIDTH)
  ) u_chksum (
    .clk           (rdclk),
    .rst           (rst),
    .clear         (ck_clear),
    .add           (ck_add),
    .din           (readData),
    .zero_with_din (ck_zero)
  );

  // In PAY the register may only be refilled if it is empty or drains this cycle.
  assign readValid = (state_q != ST_PAY) | ~out_valid_q | outReady;
  assign rd_fire   = readValid & readReady;
  assign out_take  = out_valid_q & outReady;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ok_cnt_d    = ok_cnt_q;
    err_cnt_d   = err_cnt_q;
    ck_clear    = 1'b0;
    ck_add      = 1'b0;

    if (out_take) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (rd_fire) begin
      unique case (state_q)
        ST_IDLE: begin
          if (readData == SOF_BYTE) state_d = ST_LEN;
        end
        ST_LEN: begin
          ck_clear = 1'b1;
          ck_add   = 1'b1;
          if (readData > MAX_LEN_V) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
            state_d = ST_IDLE;
          end else if (readData == '0) begin
            state_d = ST_CHK;
          end else begin
            rem_d   = readData;
            state_d = ST_PAY;
          end
        end
        ST_PAY: begin
          ck_add      = 1'b1;
          out_data_d  = readData;
          out_valid_d = 1'b1;
          out_last_d  = (rem_q == ONE_V);
          rem_d       = rem_q - ONE_V;
          if (rem_q == ONE_V) state_d = ST_CHK;
        end
        ST_CHK: begin
          done_d = 1'b1;
          err_d  = ~ck_zero;
          if (ck_zero) begin
            if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_ONE;
          end else begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_ONE;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rdclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      err_q       <= err_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign outValid  = out_valid_q;
  assign outData   = out_data_q;
  assign outLast   = out_last_q;
  assign frameDone = done_q;
  assign frameErr  = err_q;
  assign okCount   = ok_cnt_q;
  assign errCount  = err_cnt_q;

endmodule
